// File: rtl/integrator_types.sv
// Shared types and constants for the integrator / differentiator pair.
// The differentiator top stays width-generic; these typedefs describe the
// default sample and result formats used by the surrounding chain.
package integrator_types;

   localparam int W     = 10;
   localparam int M_MAX = 64;

   typedef logic signed [W-1:0] sample_t;
   typedef logic signed [W:0]   diff_t;

   // Index width for a buffer of the given depth. A depth of one still gets
   // a single-bit index so every vector has a legal width.
   function automatic int index_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/integrator_diff_hist.sv
// M-deep circular history of accepted samples for the comb differentiator.
// The read port always presents the oldest stored sample, which is the one
// about to be overwritten, i.e. x[n-M]. Slots that were never written read
// as zero, so the first M differences pass the input straight through.
module integrator_diff_hist
   import integrator_types::index_width;
#(
   parameter int W = 10,
   parameter int M = 1
) (
   input  logic         system1000,
   input  logic         system1000_rst,
   input  logic         clear,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   output logic [W-1:0] rd_data,
   output logic         primed
);

   localparam int PW = index_width(M);
   localparam int CW = index_width(M + 1);

   localparam logic [PW-1:0] PTR_LAST = PW'(M - 1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(M);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [W-1:0]  hist [M];
   logic [PW-1:0] ptr;
   logic [CW-1:0] count;

   assign rd_data = hist[ptr];
   assign primed  = (count == CNT_FULL);

   // Storage, wrap-around pointer and saturating fill count; clear wipes the
   // buffer so samples from an old stream never leak into the next one.
   always_ff @(posedge system1000 or posedge system1000_rst) begin
      if (system1000_rst) begin
         for (int i = 0; i < M; i++) begin
            hist[i] <= '0;
         end
         ptr   <= '0;
         count <= '0;
      end else if (clear) begin
         for (int i = 0; i < M; i++) begin
            hist[i] <= '0;
         end
         ptr   <= '0;
         count <= '0;
      end else if (wr_en) begin
         hist[ptr] <= wr_data;
         ptr       <= (ptr == PTR_LAST) ? '0 : ptr + PTR_ONE;
         if (count != CNT_FULL) begin
            count <= count + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/integrator_differentiator.sv
// Streaming comb differentiator y[n] = x[n] - x[n-M] with a valid/ready
// handshake and a single output register stage. With MODULAR set, the
// difference is wrapped to W bits so it exactly undoes a wrapping
// integrator; otherwise the full W+1-bit difference is produced.
module integrator_differentiator
   import integrator_types::M_MAX;
#(
   parameter int W       = 10,
   parameter int M       = 1,
   parameter int MODULAR = 1
) (
   input  logic         system1000,
   input  logic         system1000_rst,
   input  logic         clear,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W:0]   out_data,
   output logic         out_primed
);

   // Out-of-range depths are pinned to the supported 1..M_MAX window.
   localparam int DEPTH = (M < 1) ? 1 : ((M > M_MAX) ? M_MAX : M);

   logic              accept;
   logic [W-1:0]      hist_data;
   logic              hist_primed;
   logic signed [W:0] full_diff;
   logic [W-1:0]      wrapped;
   logic [W:0]        result;

   // A new sample may enter whenever the output slot is free or being
   // drained this cycle; a flush cycle never accepts data.
   assign in_ready = !clear && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   integrator_diff_hist #(
      .W (W),
      .M (DEPTH)
   ) u_hist (
      .system1000     (system1000),
      .system1000_rst (system1000_rst),
      .clear          (clear),
      .wr_en          (accept),
      .wr_data        (in_data),
      .rd_data        (hist_data),
      .primed         (hist_primed)
   );

   // Difference of the sign-extended operands, optionally wrapped back to W
   // bits and re-extended so the top two result bits always agree.
   always_comb begin
      full_diff = $signed({in_data[W-1], in_data}) - $signed({hist_data[W-1], hist_data});
      wrapped   = full_diff[W-1:0];
      if (MODULAR != 0) begin
         result = {wrapped[W-1], wrapped};
      end else begin
         result = full_diff;
      end
   end

   // Output register: load on accept, drop valid once drained, otherwise hold
   // everything still so a stalled consumer sees a stable result.
   always_ff @(posedge system1000 or posedge system1000_rst) begin
      if (system1000_rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_primed <= 1'b0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         out_data   <= result;
         out_primed <= hist_primed;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_integrator_differentiator.sv
// Self-checking bench for integrator_differentiator. Four instances with
// different depth / wrap settings share one input stream; a queue of every
// sample accepted since the last flush is the reference history.
module tb_integrator_differentiator;
   import integrator_types::*;

   logic    clk       = 1'b0;
   logic    rst       = 1'b1;
   logic    clear     = 1'b0;
   logic    in_valid  = 1'b0;
   logic    out_ready = 1'b0;
   sample_t in_data   = '0;

   logic        ir [4];
   logic        ov [4];
   logic        op [4];
   logic [10:0] od [4];

   int ms   [4] = '{1, 1, 4, 7};
   bit mods [4] = '{1, 0, 1, 0};

   int acc [$];
   bit mvalid;
   int mdata   [4];
   bit mprimed [4];

   int vectors     = 0;
   int miscompares = 0;

   int e3 [6] = '{1, 2, 3, 4, 4, 4};
   int e4 [3] = '{-512, 1023, -1023};
   int x4 [3] = '{-512, 511, -512};

   always #5 clk = ~clk;

   integrator_differentiator #(.W(10), .M(1), .MODULAR(1)) dut_m1w (
      .system1000(clk), .system1000_rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
      .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_primed(op[0]));

   integrator_differentiator #(.W(10), .M(1), .MODULAR(0)) dut_m1f (
      .system1000(clk), .system1000_rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
      .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_primed(op[1]));

   integrator_differentiator #(.W(10), .M(4), .MODULAR(1)) dut_m4w (
      .system1000(clk), .system1000_rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
      .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_primed(op[2]));

   integrator_differentiator #(.W(10), .M(7), .MODULAR(0)) dut_m7f (
      .system1000(clk), .system1000_rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(ir[3]), .in_data(in_data),
      .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .out_primed(op[3]));

   // Reference result for instance k from the newest accepted sample and the
   // sample M positions earlier in the stream (zero if the stream is shorter).
   function automatic int ref_diff(input int k);
      int n, x, prev, d;
      n    = acc.size();
      x    = acc[n-1];
      prev = (n - 1 >= ms[k]) ? acc[n-1-ms[k]] : 0;
      d    = x - prev;
      if (mods[k]) begin
         d = d & 1023;
         if (d >= 512) d = d - 1024;
      end
      return d;
   endfunction

   task automatic chk(input string tag, input int k, input logic signed [31:0] obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s[%0d]: observed %0d expected %0d", tag, k, obs, exp);
      end
   endtask

   task automatic check_output();
      for (int k = 0; k < 4; k++) begin
         chk("out_valid", k, ov[k], int'(mvalid));
         chk("out_data", k, $signed(od[k]), mdata[k]);
         chk("out_primed", k, op[k], int'(mprimed[k]));
      end
   endtask

   task automatic expect_out(input int k, input int y, input int p);
      chk("spec_data", k, $signed(od[k]), y);
      chk("spec_primed", k, op[k], p);
   endtask

   task automatic model_reset();
      acc.delete();
      mvalid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         mdata[k]   = 0;
         mprimed[k] = 1'b0;
      end
   endtask

   // One clock of stimulus: drive inputs, check in_ready, step, update the
   // reference, then check every output register.
   task automatic apply_stimulus(input bit iv, input int data, input bit ordy, input bit clr);
      bit exp_ready;
      in_valid  = iv;
      in_data   = sample_t'(data);
      out_ready = ordy;
      clear     = clr;
      #1;
      exp_ready = !clr && (!mvalid || ordy);
      for (int k = 0; k < 4; k++) chk("in_ready", k, ir[k], int'(exp_ready));
      @(posedge clk);
      if (iv && exp_ready) begin
         acc.push_back(data);
         mvalid = 1'b1;
         for (int k = 0; k < 4; k++) begin
            mdata[k]   = ref_diff(k);
            mprimed[k] = (acc.size() - 1) >= ms[k];
         end
      end else if (ordy) begin
         mvalid = 1'b0;
      end
      if (clr) acc.delete();
      #1;
      check_output();
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_output();
      rst = 1'b0;

      // Basic M=1 difference and priming
      apply_stimulus(1, 5, 1, 0);   expect_out(0, 5, 0);
      apply_stimulus(1, 15, 1, 0);  expect_out(0, 10, 1);
      apply_stimulus(1, 12, 1, 0);  expect_out(0, -3, 1);

      // Wrap versus full-range result
      apply_stimulus(0, 0, 1, 1);
      apply_stimulus(1, 510, 1, 0);  expect_out(0, 510, 0);  expect_out(1, 510, 0);
      apply_stimulus(1, -506, 1, 0); expect_out(0, 8, 1);    expect_out(1, -1016, 1);

      // Depth 4 ramp
      apply_stimulus(0, 0, 1, 1);
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(1, i + 1, 1, 0);
         expect_out(2, e3[i], (i >= 4) ? 1 : 0);
      end

      // Extremes, full range
      apply_stimulus(0, 0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1, x4[i], 1, 0);
         expect_out(1, e4[i], (i >= 1) ? 1 : 0);
      end

      // Backpressure: output held, nothing accepted, nothing lost
      apply_stimulus(0, 0, 1, 1);
      apply_stimulus(1, 100, 1, 0);
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1, 200 + i, 0, 0);
         chk("bp_in_ready", 0, ir[0], 0);
         expect_out(0, 100, 0);
      end
      apply_stimulus(1, 300, 1, 0);  expect_out(0, 200, 1);  expect_out(2, 300, 0);
      apply_stimulus(0, 0, 1, 0);

      // Clear beats a valid sample; next sample sees empty history
      apply_stimulus(1, 55, 1, 1);
      apply_stimulus(1, 7, 1, 0);
      for (int k = 0; k < 4; k++) expect_out(k, 7, 0);
      apply_stimulus(1, -40, 1, 0);
      apply_stimulus(1, 90, 0, 0);

      // Asynchronous reset while a result is pending
      rst      = 1'b1;
      in_valid = 1'b0;
      #1;
      model_reset();
      check_output();
      @(posedge clk);
      #1;
      rst = 1'b0;
      apply_stimulus(1, 9, 1, 0);
      for (int k = 0; k < 4; k++) expect_out(k, 9, 0);

      // Randomized traffic with random stalls and occasional flushes
      for (int i = 0; i < 400; i++) begin
         apply_stimulus(($urandom % 4) != 0,
                        int'($urandom_range(0, 1023)) - 512,
                        ($urandom % 3) != 0,
                        ($urandom % 40) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
